// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: drives hcount/vcount, syncs and blanking
// on the packed VGA bus (rgb held at 0) plus line/frame start pulses.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_POL = 1'b0,
    localparam int  VGA_BUS_SIZE = 38
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    run,
    output logic [VGA_BUS_SIZE-1:0] vga_out,
    output logic                    frame_start,
    output logic                    line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 11 bits wide, so a raster larger than 2048 in either axis cannot be represented.
    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_timing
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
        end
    endgenerate

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
    localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_BEG     = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    // Sync and blanking are decoded from the next counts so all bus fields describe one pixel.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (run) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = 11'd0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = 11'd0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 11'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
        hblnk_d = (hcount_d >= H_BLNK_BEG);
        vblnk_d = (vcount_d >= V_BLNK_BEG);
        hs_d    = (hcount_d >= HS_BEG && hcount_d <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_d    = (vcount_d >= VS_BEG && vcount_d <= VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_out     = {hcount_q, vcount_q, hs_q, vs_q, hblnk_q, vblnk_q, 12'h000};
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA raster timing generator; first stage of the video pipeline.
- Produces hcount/vcount, sync and blanking on the packed VGA bus, with rgb held at 0.
- Downstream overlay stages (background, rectangle/card drawers, mouse) consume the bus.
- Defaults are 1024x768 @ 60 Hz with a 65 MHz pclk.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels); H_TOTAL = sum = 1344
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
SYNC_POL, 1'b0, active level of hs/vs (0 = active-low)

Ports:
pclk  in  1  pixel clock
rst  in  1  reset: synchronous, active-high; clock pclk
run  in  1  count enable; 0 freezes all counters and outputs
vga_out  out  VGA_BUS_SIZE  packed VGA bus: hcount[10:0], vcount[10:0], hs, vs, hblnk, vblnk, rgb[11:0]; built with the team bus-merge macro
frame_start  out  1  one-cycle pulse when the bus shows pixel (0,0) after a frame wrap
line_start  out  1  one-cycle pulse when the bus shows hcount=0

Behaviour:
- Registered outputs:
  - All bus fields and pulses come from flops.
  - hs/vs/hblnk/vblnk are computed from the next-count values, so every field on the bus describes the same pixel (no skew between fields).
- Reset (rst=1 at a pclk edge):
  - hcount=0, vcount=0, hblnk=0, vblnk=0.
  - hs=vs=~SYNC_POL (inactive); rgb=0.
  - frame_start=0, line_start=0.
  - Reset overrides run.
  - Reset asserted mid-frame returns the bus to (0,0) on the next edge.
- Counting (run=1, rst=0):
  - hcount increments by 1 each cycle.
  - At hcount=H_TOTAL-1 (1343), hcount wraps to 0 and vcount increments.
  - At hcount=1343 with vcount=V_TOTAL-1 (805), both wrap to 0.
  - Counters never take values >= their total.
- Stall (run=0): all registers hold, pulses forced to 0. On resume, counting continues from the held pixel.
- hblnk = 1 for hcount in [H_ACTIVE, H_TOTAL-1] = [1024,1343].
- vblnk = 1 for vcount in [V_ACTIVE, V_TOTAL-1] = [768,805].
- hs = SYNC_POL for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048,1183], else ~SYNC_POL.
- vs = SYNC_POL for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [771,776], else ~SYNC_POL. vs changes at the same edge as hcount wraps to 0.
- rgb field constant 0; downstream stages paint over it.
- line_start:
  - =1 on every edge where the bus hcount becomes 0 by wrap.
  - Not asserted on the first cycle after reset release (the bus already shows 0 there); asserted at the first wrap.
- frame_start: =1 only where both counters become 0 by wrap. Same exclusion rule as line_start.
- Timing:
  - Frame period = H_TOTAL*V_TOTAL = 1,083,264 cycles (~60.0 Hz at 65 MHz).
  - Latency from rst deassert to first hcount=1 is 1 cycle.
- Arithmetic: counters are 11 bits unsigned; parameter totals must be <= 2048 (synthesis-time check; error if exceeded).

Test Plan:
1. Reset release: hold rst 5 cycles, then release with run=1 -> bus (0,0), hs=vs=1, blanks 0, rgb 0 during reset; hcount=1 one cycle after release; no pulse.
2. Horizontal line (run=1) -> hblnk rises at hcount=1024; hs=0 exactly for 1048..1183 (136 cycles); hcount 1343 -> 0 with vcount 0 -> 1 and line_start=1 on that cycle.
3. Full frame -> vblnk=1 for vcount 768..805; vs=0 for lines 771..776 (6*1344=8064 cycles); frame_start pulses once per 1,083,264 cycles.
4. run=0 for 10 cycles at hcount=1342, vcount=805 -> bus frozen, pulses 0; after resume: 1343 then (0,0) with frame_start=1.
5. Assert rst at hcount=500, vcount=400 -> next edge bus (0,0), syncs inactive, pulses 0; counting restarts cleanly.
6. Parameter override 640x480 (800x525; FP 16/10, sync 96/2) -> hs low 656..751, vs low 490..491, frame period 420,000 cycles.
